fp_add_arbiter: RTL and testbench



---
 rtl/fp_add_arbiter.sv | 127 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Lets NUM_REQ client datapaths share one single-precision IEEE adder.
//   Each cycle a round-robin arbiter may accept one operation. Its operands
//   are registered onto the adder inputs, and its requester tag travels down a
//   pipeline that matches the adder latency. When the result comes out of the
//   adder, it is returned to the requester that issued the operation.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   req_valid/req_ready per-requester valid/ready handshake (ready is one-hot or zero)
//   req_a/req_b/req_op  packed operands; requester i uses bits [32*i +: 32]; op 1 = A-B
//   resp_valid          one-cycle result pulse to the issuing requester
//   resp_result         adder result, shared by all requesters
//   resp_idx            index of the requester receiving the result
//   number1/number2/op  registered operands to the adder
//   result              adder output
//   inflight            number of operations issued but not yet returned
//   busy                work is pending or requested
module fp_add_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDER_LATENCY = 1,
  parameter int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [31:0]          resp_result,
  output logic [IDX_W-1:0]     resp_idx,
  output logic [31:0]          number1,
  output logic [31:0]          number2,
  output logic                 op,
  input  logic [31:0]          result,
  output logic [IDX_W+1:0]     inflight,
  output logic                 busy
);

  logic [IDX_W-1:0]                 ptr;
  logic                             grant_found;
  logic [IDX_W-1:0]                 grant_idx;
  logic                             issue;
  logic [ADDER_LATENCY:0]           tag_vld;
  logic [ADDER_LATENCY:0][IDX_W-1:0] tag_idx;
  logic                             out_vld;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Search starts just after the last winner. This makes the last winner the
  // lowest priority and gives a bounded wait to everyone else.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_idx(int'(ptr) + k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(ptr) + k);
      end
    end
    if (grant_found && !rst) req_ready[grant_idx] = 1'b1;
  end

  assign issue = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number1 <= '0;
      number2 <= '0;
      op      <= 1'b0;
      ptr     <= IDX_W'(NUM_REQ - 1);
    end else if (issue) begin
      number1 <= req_a[32*int'(grant_idx) +: 32];
      number2 <= req_b[32*int'(grant_idx) +: 32];
      op      <= req_op[grant_idx];
      ptr     <= grant_idx;
    end
  end

  // Stage k holds the tag of the operation whose operands went to the adder
  // k cycles ago. The last stage is therefore aligned with result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_idx <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_idx[0] <= grant_idx;
      for (int k = ADDER_LATENCY; k >= 1; k--) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  assign out_vld = tag_vld[ADDER_LATENCY];

  always_comb begin
    resp_valid = '0;
    resp_idx   = '0;
    if (out_vld) begin
      resp_valid[tag_idx[ADDER_LATENCY]] = 1'b1;
      resp_idx                           = tag_idx[ADDER_LATENCY];
    end
  end

  assign resp_result = result;

  // When an issue and a response happen in the same cycle, the count stays the same.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue && !out_vld) begin
      inflight <= inflight + (IDX_W+2)'(1);
    end else if (!issue && out_vld) begin
      inflight <= inflight - (IDX_W+2)'(1);
    end
  end

  assign busy = (inflight != '0) || (|req_valid);

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_op;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference adder: widen both operands to double, do the arithmetic in
  // real, and narrow the result back to single by truncation. Denormals are
  // flushed to zero.
  function automatic real sp2real(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:23] == 8'd0) return 0.0;
    e = 11'(a[30:23]) + 11'd896;
    return $bitstoreal({a[31], e, a[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real         r;
    logic [63:0] d;
    int          e;
    r = sub ? sp2real(a) - sp2real(b) : sp2real(a) + sp2real(b);
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0) return {d[63], 31'd0};
    e = e - 1023 + 127;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(150, 105)), 23'($urandom)};
  endfunction

  // Three copies of the arbiter, one per adder latency, see the same stimulus.
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [31:0] resp_result;
    logic [1:0]  resp_idx;
    logic [31:0] number1;
    logic [31:0] number2;
    logic        op;
    logic [31:0] result;
    logic [3:0]  inflight;
    logic        busy;

    fp_add_arbiter #(.NUM_REQ(4), .ADDER_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_idx(resp_idx),
      .number1(number1), .number2(number2), .op(op),
      .result(result), .inflight(inflight), .busy(busy)
    );

    if (L == 0) begin : g_comb
      always_comb result = fp_ref(number1, number2, op);
    end else begin : g_pipe
      logic [31:0] apipe [L];
      always @(posedge clk) begin
        apipe[0] <= fp_ref(number1, number2, op);
        for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
      end
      assign result = apipe[L-1];
    end

    // Reference model. The expected response for each cycle is kept in a
    // ring indexed by cycle number.
    int          m_ptr = 3;
    int          m_inf = 0;
    logic [31:0] m_n1 = '0;
    logic [31:0] m_n2 = '0;
    logic        m_op = 1'b0;
    logic        rv_ring [16];
    int          ri_ring [16];
    logic [31:0] rr_ring [16];
    int          peak = 0;
    logic [31:0] cap  [4];
    int          capc [4];

    initial begin
      for (int i = 0; i < 16; i++) rv_ring[i] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        cap[i]  = '0;
        capc[i] = -100;
      end
    end

    always begin
      int slot, g_exp, best, d, ns;
      @(negedge clk);
      #1;
      slot = cyc % 16;
      if (rst) begin
        check($sformatf("L%0d_rst_ready", L), 32'(req_ready), 32'd0);
        check($sformatf("L%0d_rst_resp_valid", L), 32'(resp_valid), 32'd0);
        check($sformatf("L%0d_rst_resp_idx", L), 32'(resp_idx), 32'd0);
        check($sformatf("L%0d_rst_inflight", L), 32'(inflight), 32'd0);
        check($sformatf("L%0d_rst_number1", L), number1, 32'd0);
        check($sformatf("L%0d_rst_number2", L), number2, 32'd0);
        check($sformatf("L%0d_rst_op", L), 32'(op), 32'd0);
        m_ptr = 3;
        m_inf = 0;
        m_n1  = '0;
        m_n2  = '0;
        m_op  = 1'b0;
        for (int i = 0; i < 16; i++) rv_ring[i] = 1'b0;
      end else begin
        // Winner: the valid requester closest after the previous winner in circular order.
        g_exp = -1;
        best  = 99;
        for (int i = 0; i < 4; i++) begin
          if (req_valid[i]) begin
            d = (i - m_ptr - 1 + 8) % 4;
            if (d < best) begin
              best  = d;
              g_exp = i;
            end
          end
        end
        check($sformatf("L%0d_ready", L), 32'(req_ready), (g_exp >= 0) ? (32'd1 << g_exp) : 32'd0);
        check($sformatf("L%0d_resp_valid", L), 32'(resp_valid),
              rv_ring[slot] ? (32'd1 << ri_ring[slot]) : 32'd0);
        if (rv_ring[slot]) begin
          check($sformatf("L%0d_resp_idx", L), 32'(resp_idx), 32'(ri_ring[slot]));
          check($sformatf("L%0d_resp_result", L), resp_result, rr_ring[slot]);
        end
        check($sformatf("L%0d_inflight", L), 32'(inflight), 32'(m_inf));
        check($sformatf("L%0d_busy", L), 32'(busy), 32'((m_inf != 0) || (req_valid != 4'd0)));
        check($sformatf("L%0d_number1", L), number1, m_n1);
        check($sformatf("L%0d_number2", L), number2, m_n2);
        check($sformatf("L%0d_op", L), 32'(op), 32'(m_op));
        if (resp_valid != 4'd0) begin
          cap[resp_idx]  = resp_result;
          capc[resp_idx] = cyc;
        end
        if (int'(inflight) > peak) peak = int'(inflight);
        m_inf = m_inf + int'(g_exp >= 0) - int'(rv_ring[slot]);
        rv_ring[slot] = 1'b0;
        if (g_exp >= 0) begin
          ns          = (cyc + 1 + L) % 16;
          rv_ring[ns] = 1'b1;
          ri_ring[ns] = g_exp;
          rr_ring[ns] = fp_ref(req_a[32*g_exp +: 32], req_b[32*g_exp +: 32], req_op[g_exp]);
          m_n1        = req_a[32*g_exp +: 32];
          m_n2        = req_b[32*g_exp +: 32];
          m_op        = req_op[g_exp];
          m_ptr       = g_exp;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic o);
    req_valid[i]     = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[i]        = o;
  endtask

  // Ends the current cycle. A requester that was granted drops its valid at
  // the next falling edge.
  task automatic step();
    logic [3:0] hs;
    #1;
    hs = g_lane[1].req_ready & req_valid;
    @(negedge clk);
    cyc++;
    if (!rst) req_valid = req_valid & ~hs;
  endtask

  initial begin
    int c0, d;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();

    // Single subtract from requester 2.
    set_req(2, 32'h40ADF06F, 32'h40ADEAB3, 1'b1);
    c0 = cyc;
    repeat (7) step();
    check("single_result", g_lane[1].cap[2], 32'h3A378000);
    check("single_latency_l1", 32'(g_lane[1].capc[2]), 32'(c0 + 2));
    check("single_latency_l0", 32'(g_lane[0].capc[2]), 32'(c0 + 1));
    check("single_latency_l3", 32'(g_lane[2].capc[2]), 32'(c0 + 4));

    // All four requesters valid continuously.
    repeat (12) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i]) set_req(i, rand_fp(), rand_fp(), 1'($urandom));
      step();
    end
    req_valid = '0;
    repeat (6) step();
    check("peak_l0", 32'(g_lane[0].peak), 32'd1);
    check("peak_l1", 32'(g_lane[1].peak), 32'd2);
    check("peak_l3", 32'(g_lane[2].peak), 32'd4);

    // Mixed add and subtract, granted back to back.
    set_req(1, 32'hC0000000, 32'h41100000, 1'b0);
    set_req(3, 32'h40ADF06F, 32'h40ADEAB3, 1'b1);
    repeat (7) step();
    check("mixed_add", g_lane[1].cap[1], 32'h40E00000);
    check("mixed_sub", g_lane[1].cap[3], 32'h3A378000);
    d = g_lane[1].capc[1] - g_lane[1].capc[3];
    check("mixed_consecutive", 32'((d == 1) || (d == -1)), 32'd1);

    // Reset asserted while an operation is still in flight.
    set_req(1, rand_fp(), rand_fp(), 1'b0);
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    set_req(0, rand_fp(), rand_fp(), 1'b1);
    set_req(3, rand_fp(), rand_fp(), 1'b0);
    #1;
    check("rst_regrant", 32'(g_lane[1].req_ready), 32'd1);
    repeat (8) step();
    req_valid = '0;

    // Random traffic.
    repeat (300) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, rand_fp(), rand_fp(), 1'($urandom));
      step();
    end
    req_valid = '0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
